// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode sequencer for first_cpu.
// Fetches 8-bit instructions from a synchronous ROM, decodes them into operand/destination
// addresses and an ALU op, and sequences FETCH-DECODE-READ-EXEC-WB (5 cycles/instruction).
// Optional feature: define STEP_MODE_EN to add a 'step' input and a STEP_WAIT state after WB.
module cpu_control_unit #(
    parameter int unsigned PC_WIDTH = 3,
    parameter int unsigned PROG_LEN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
`ifdef STEP_MODE_EN
    input  logic                step,
`endif
    input  logic [7:0]          instr_data,
    output logic [PC_WIDTH-1:0] instr_addr,
    output logic [1:0]          src1_addr,
    output logic [1:0]          src2_addr,
    output logic [1:0]          dst_addr,
    output logic [1:0]          alu_op,
    output logic                alu_en,
    output logic                reg_write,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StRead,
        StExec,
        StWb,
        StHalt
`ifdef STEP_MODE_EN
        ,
        StStepWait
`endif
    } state_e;

    // pc value of the final instruction; WB of this pc goes to HALT
    localparam logic [PC_WIDTH-1:0] LastPc = PC_WIDTH'(PROG_LEN - 1);

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;

    // ROM address is the program counter itself, so it is registered by construction
    assign instr_addr = pc_q;

    // Sequencer: state, pc and all registered outputs advance together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            src1_addr <= '0;
            src2_addr <= '0;
            dst_addr  <= '0;
            alu_op    <= '0;
            alu_en    <= 1'b0;
            reg_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Strobes are single-cycle; only the READ->EXEC and EXEC->WB edges raise them
            alu_en    <= 1'b0;
            reg_write <= 1'b0;
            if (abort) begin
                // Address/op registers deliberately keep their last values
                state_q <= StIdle;
                pc_q    <= '0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StHalt: begin
                        if (start) begin
                            state_q <= StFetch;
                            pc_q    <= '0;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                    StFetch: begin
                        state_q <= StDecode;
                    end
                    StDecode: begin
                        // ROM data for pc became valid this cycle
                        alu_op    <= instr_data[7:6];
                        dst_addr  <= instr_data[5:4];
                        src1_addr <= instr_data[3:2];
                        src2_addr <= instr_data[1:0];
                        state_q   <= StRead;
                    end
                    StRead: begin
                        state_q <= StExec;
                        alu_en  <= 1'b1;
                    end
                    StExec: begin
                        state_q   <= StWb;
                        reg_write <= 1'b1;
                    end
                    StWb: begin
                        pc_q <= pc_q + 1'b1;
                        if (pc_q == LastPc) begin
                            state_q <= StHalt;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
`ifdef STEP_MODE_EN
                            state_q <= StStepWait;
`else
                            state_q <= StFetch;
`endif
                        end
                    end
`ifdef STEP_MODE_EN
                    StStepWait: begin
                        if (step) begin
                            state_q <= StFetch;
                        end
                    end
`endif
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
